// File: rtl/binary_round_controller.sv
// binary_round_controller
// Round sequencer for the binary game: picks a pseudo-random 8-bit target per
// round, runs a per-round countdown, judges the switch value against the target
// and keeps the running score. A game ends after ROUNDS rounds or on Quit.
//
// Optional feature macro: BRC_STREAK_BONUS_EN
//   defined   -> the 3rd and later consecutive correct answers score 2
//   undefined -> every correct answer scores 1, no streak register exists
//
// Input contract: Start, Submit and Quit are single-cycle pulses from
// debounced sources. There is no back-pressure. Every cycle a pulse is high
// counts as one event, and it is acted on only in the states that accept it.
// Events in any other state are dropped.
module binary_round_controller #(
    parameter int         ROUNDS        = 10,
    parameter int         TICKS_PER_SEC = 100000000,
    parameter int         ROUND_SECS    = 10,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Start,
    input  logic       Submit,
    input  logic       Quit,
    input  logic [7:0] userNumber,
    output logic [7:0] targetNumber,
    output logic [3:0] timeLeft,
    output logic [3:0] roundNum,
    output logic [7:0] playerScore,
    output logic       lastCorrect,
    output logic       q_Idle,
    output logic       q_NewRound,
    output logic       q_Play,
    output logic       q_Judge,
    output logic       q_Done
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_NEWROUND = 3'd1;
    localparam logic [2:0] S_PLAY     = 3'd2;
    localparam logic [2:0] S_JUDGE    = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    localparam int            TW       = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(TICKS_PER_SEC - 1);

    logic [2:0]    state;
    logic [2:0]    state_next;
    logic [7:0]    lfsr;
    logic [TW-1:0] tick;
    logic          match_q;
    logic [7:0]    score_add;
    logic [8:0]    score_sum;

    logic start_ok;
    logic quit_ok;
    logic tick_wrap;
    logic timeout;
    logic to_judge;

    // Start only counts from IDLE or DONE; Quit only while a round is running.
    assign start_ok  = Start && ((state == S_IDLE) || (state == S_DONE));
    assign quit_ok   = Quit && ((state == S_NEWROUND) || (state == S_PLAY) || (state == S_JUDGE));
    assign tick_wrap = (tick == TICK_MAX);
    assign timeout   = (state == S_PLAY) && tick_wrap && (timeLeft == 4'd1);
    // Quit beats both Submit and timeout. Submit and timeout lead to the same
    // state, and match_q records which one it was.
    assign to_judge  = (state == S_PLAY) && !Quit && (Submit || timeout);

    assign q_Idle     = (state == S_IDLE);
    assign q_NewRound = (state == S_NEWROUND);
    assign q_Play     = (state == S_PLAY);
    assign q_Judge    = (state == S_JUDGE);
    assign q_Done     = (state == S_DONE);

`ifdef BRC_STREAK_BONUS_EN
    logic [1:0] streak;

    // Count consecutive correct answers, saturating at 3; a miss, Quit or Start clears it.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            streak <= 2'd0;
        end else if (start_ok || quit_ok) begin
            streak <= 2'd0;
        end else if (state == S_JUDGE) begin
            if (match_q) begin
                streak <= (streak == 2'd3) ? 2'd3 : streak + 2'd1;
            end else begin
                streak <= 2'd0;
            end
        end
    end

    // Two or more correct answers already in a row means this one is the 3rd or later.
    assign score_add = streak[1] ? 8'd2 : 8'd1;
`else
    assign score_add = 8'd1;
`endif

    assign score_sum = {1'b0, playerScore} + {1'b0, score_add};

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     if (Start) state_next = S_NEWROUND;
            S_NEWROUND: state_next = Quit ? S_DONE : S_PLAY;
            S_PLAY: begin
                if (Quit)          state_next = S_DONE;
                else if (to_judge) state_next = S_JUDGE;
            end
            S_JUDGE: begin
                if (Quit || (roundNum == 4'(ROUNDS))) state_next = S_DONE;
                else                                  state_next = S_NEWROUND;
            end
            S_DONE:     if (Start) state_next = S_NEWROUND;
            default:    state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    // Free-running Fibonacci LFSR, x^8+x^6+x^5+x^4+1. It advances every cycle, so targets depend on when play starts.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) lfsr <= LFSR_SEED;
        else          lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    // Countdown timer. It reloads in NEWROUND, runs only in PLAY, and freezes on Quit.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            tick     <= '0;
            timeLeft <= 4'd0;
        end else if ((state == S_NEWROUND) && !Quit) begin
            tick     <= '0;
            timeLeft <= 4'(ROUND_SECS);
        end else if ((state == S_PLAY) && !Quit) begin
            if (tick_wrap) begin
                tick     <= '0;
                timeLeft <= timeLeft - 4'd1;
            end else begin
                tick <= tick + TW'(1);
            end
        end
    end

    // Round bookkeeping: the target and round number load in NEWROUND, and the verdict is captured on leaving PLAY.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            targetNumber <= 8'd0;
            roundNum     <= 4'd0;
            match_q      <= 1'b0;
        end else begin
            if (start_ok) begin
                roundNum <= 4'd0;
            end else if ((state == S_NEWROUND) && !Quit) begin
                targetNumber <= lfsr;
                roundNum     <= roundNum + 4'd1;
            end
            if (to_judge) begin
                match_q <= Submit && (userNumber == targetNumber);
            end
        end
    end

    // Score and last result. JUDGE applies its update even when Quit arrives in the same cycle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            playerScore <= 8'd0;
            lastCorrect <= 1'b0;
        end else if (start_ok) begin
            playerScore <= 8'd0;
            lastCorrect <= 1'b0;
        end else if (state == S_JUDGE) begin
            lastCorrect <= match_q;
            if (match_q) begin
                playerScore <= score_sum[8] ? 8'hFF : score_sum[7:0];
            end
        end
    end

endmodule
